// File: rtl/div_ctrl_pkg.sv
// Shared encodings for the iterative divider: FSM states, fixed latency and
// the memory-stage div_op select bits used by the execute and memory stages.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Cycles from request acceptance to div_done.
    localparam int DIV_LATENCY = 33;

    localparam int DIV_OP_QUO_BIT = 0;
    localparam int DIV_OP_REM_BIT = 1;

endpackage

// File: rtl/div_ctrl_step.sv
// One restoring shift-subtract iteration; purely combinational.
// The shifted partial remainder is WIDTH+1 bits wide so the compare never overflows.
module div_ctrl_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dsr,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_borrow;

    assign w_shift  = {i_rem, i_bit};
    assign w_borrow = w_shift < {1'b0, i_dsr};
    assign w_diff   = w_shift - {1'b0, i_dsr};

    // Both candidates are below the divisor here, so they fit in WIDTH bits.
    assign o_rem  = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign o_qbit = ~w_borrow;

endmodule

// File: rtl/div_ctrl.sv
// Iterative signed/unsigned divider with its sequencing FSM; one quotient bit per cycle,
// results held stable after DONE until the next completed operation or reset.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_req,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_src1,
    input  logic [WIDTH-1:0] div_src2,
    input  logic             div_ack,
    input  logic             div_flush,
    output logic             div_busy,
    output logic             div_done,
    output logic [WIDTH-1:0] div_result,
    output logic [WIDTH-1:0] mod_result
);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic             r_qsign;
    logic             r_rsign;
    logic [WIDTH-1:0] r_div_result;
    logic [WIDTH-1:0] r_mod_result;

    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_qbit;
    logic [WIDTH-1:0] w_quo_next;
    logic             w_last;
    logic             w_dsr_zero;

    assign w_abs1 = (div_signed && div_src1[WIDTH-1]) ? (~div_src1 + 1'b1) : div_src1;
    assign w_abs2 = (div_signed && div_src2[WIDTH-1]) ? (~div_src2 + 1'b1) : div_src2;

    div_ctrl_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_dvd[WIDTH-1]),
        .i_dsr  (r_dsr),
        .o_rem  (w_rem_next),
        .o_qbit (w_qbit)
    );

    assign w_quo_next = {r_quo[WIDTH-2:0], w_qbit};
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_dsr_zero = (r_dsr == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= DIV_IDLE;
            r_cnt        <= '0;
            r_dvd        <= '0;
            r_dsr        <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_qsign      <= 1'b0;
            r_rsign      <= 1'b0;
            r_div_result <= '0;
            r_mod_result <= '0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (div_req && !div_flush) begin
                        r_dvd   <= w_abs1;
                        r_dsr   <= w_abs2;
                        r_rem   <= '0;
                        r_quo   <= '0;
                        r_cnt   <= '0;
                        r_qsign <= div_signed && (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
                        r_rsign <= div_signed && div_src1[WIDTH-1];
                        r_state <= DIV_CALC;
                    end
                end
                DIV_CALC: begin
                    if (div_flush) begin
                        r_state <= DIV_IDLE;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            // A zero divisor leaves quotient all-ones and the remainder
                            // equal to |dividend|; re-signing the remainder restores the dividend.
                            r_div_result <= (r_qsign && !w_dsr_zero) ? (~w_quo_next + 1'b1) : w_quo_next;
                            r_mod_result <= r_rsign ? (~w_rem_next + 1'b1) : w_rem_next;
                            r_state      <= DIV_DONE;
                        end
                    end
                end
                DIV_DONE: begin
                    if (div_flush || div_ack) begin
                        r_state <= DIV_IDLE;
                    end
                end
                default: r_state <= DIV_IDLE;
            endcase
        end
    end

    assign div_busy   = (r_state != DIV_IDLE);
    assign div_done   = (r_state == DIV_DONE);
    assign div_result = r_div_result;
    assign mod_result = r_mod_result;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: transaction-level reference model checked every cycle,
// plus directed literal cases and randomized operations.
module tb_div_ctrl;

    logic        clk;
    logic        reset;
    logic        div_req;
    logic        div_signed;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        div_ack;
    logic        div_flush;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_result;
    logic [31:0] mod_result;

    int n_cmp = 0;
    int n_bad = 0;

    div_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .div_req    (div_req),
        .div_signed (div_signed),
        .div_src1   (div_src1),
        .div_src2   (div_src2),
        .div_ack    (div_ack),
        .div_flush  (div_flush),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .div_result (div_result),
        .mod_result (mod_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result of div.w/mod.w/div.wu/mod.wu.
    function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
    endfunction

    // Transaction-level model: busy/done flags, cycles left, expected results.
    logic        m_busy, m_done, m_on;
    int          m_left;
    logic [31:0] m_q, m_r, m_pq, m_pr;

    initial begin
        m_busy = 0; m_done = 0; m_left = 0; m_q = 0; m_r = 0; m_pq = 0; m_pr = 0; m_on = 0;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_left = 0; m_q = 0; m_r = 0;
        end else if (!m_busy) begin
            if (div_req && !div_flush) begin
                m_busy = 1;
                m_left = 32;
                ref_div(div_signed, div_src1, div_src2, m_pq, m_pr);
            end
        end else if (!m_done) begin
            if (div_flush) begin
                m_busy = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1;
                    m_q    = m_pq;
                    m_r    = m_pr;
                end
            end
        end else if (div_flush || div_ack) begin
            m_busy = 0;
            m_done = 0;
        end
        m_on = 1;
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("model busy", {31'd0, div_busy}, {31'd0, m_busy});
            chk("model done", {31'd0, div_done}, {31'd0, m_done});
            chk("model quotient", div_result, m_q);
            chk("model remainder", mod_result, m_r);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one op, measure latency, hold DONE for 'hold' cycles (with ignored requests), then ack.
    task automatic run_op(input string nm, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input logic lit, input logic [31:0] eq, input logic [31:0] er);
        int lat;
        logic [31:0] q, r;
        if (lit) begin
            q = eq; r = er;
        end else begin
            ref_div(s, a, b, q, r);
        end
        div_req = 1; div_signed = s; div_src1 = a; div_src2 = b;
        tick;
        div_req = 0;
        lat = 1;
        while (!div_done && lat < 40) begin
            tick;
            lat++;
        end
        chk({nm, " latency"}, lat, 33);
        chk({nm, " quotient"}, div_result, q);
        chk({nm, " remainder"}, mod_result, r);
        for (int i = 0; i < hold; i++) begin
            div_req = 1; div_signed = $urandom_range(0, 1);
            div_src1 = $urandom; div_src2 = $urandom;
            tick;
            chk({nm, " hold done"}, {31'd0, div_done}, 32'd1);
            chk({nm, " hold quotient"}, div_result, q);
        end
        div_req = 0;
        div_ack = 1;
        tick;
        div_ack = 0;
        chk({nm, " done after ack"}, {31'd0, div_done}, 32'd0);
        chk({nm, " quotient after ack"}, div_result, q);
        chk({nm, " remainder after ack"}, mod_result, r);
    endtask

    initial begin
        logic [31:0] a, b;
        int sel;
        reset = 1; div_req = 0; div_signed = 0; div_src1 = 0; div_src2 = 0;
        div_ack = 0; div_flush = 0;
        tick; tick;
        chk("reset busy", {31'd0, div_busy}, 32'd0);
        chk("reset done", {31'd0, div_done}, 32'd0);
        chk("reset quotient", div_result, 32'd0);
        chk("reset remainder", mod_result, 32'd0);
        reset = 0;
        tick;

        run_op("u100/7", 0, 32'd100, 32'd7, 0, 1, 32'd14, 32'd2);
        run_op("s-7/2", 1, 32'hFFFF_FFF9, 32'd2, 0, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("u-7/2", 0, 32'hFFFF_FFF9, 32'd2, 0, 1, 32'h7FFF_FFFC, 32'd1);
        run_op("u/0", 0, 32'h1234_5678, 32'd0, 0, 1, 32'hFFFF_FFFF, 32'h1234_5678);
        run_op("s-7/0", 1, 32'hFFFF_FFF9, 32'd0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
        run_op("s ovf", 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'h8000_0000, 32'd0);

        // Flush during CALC: request at cycle 0, flush at cycle 10.
        div_req = 1; div_signed = 0; div_src1 = 32'd1000; div_src2 = 32'd3;
        tick;
        div_req = 0;
        for (int i = 1; i < 10; i++) tick;
        div_flush = 1;
        tick;
        div_flush = 0;
        chk("flush busy", {31'd0, div_busy}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            tick;
            chk("flush no done", {31'd0, div_done}, 32'd0);
        end
        chk("flush quotient kept", div_result, 32'h8000_0000);
        chk("flush remainder kept", mod_result, 32'd0);
        run_op("5/5", 0, 32'd5, 32'd5, 0, 1, 32'd1, 32'd0);

        // Flush together with request in IDLE is not accepted.
        div_req = 1; div_flush = 1; div_src1 = 32'd9; div_src2 = 32'd2;
        tick;
        div_req = 0; div_flush = 0;
        chk("flush+req busy", {31'd0, div_busy}, 32'd0);
        tick;

        run_op("ack late", 0, 32'd77, 32'd10, 5, 1, 32'd7, 32'd7);

        // Reset in the middle of CALC.
        div_req = 1; div_signed = 1; div_src1 = 32'hFFFF_FF00; div_src2 = 32'd3;
        tick;
        div_req = 0;
        for (int i = 1; i < 20; i++) tick;
        reset = 1;
        tick;
        reset = 0;
        chk("midreset busy", {31'd0, div_busy}, 32'd0);
        chk("midreset done", {31'd0, div_done}, 32'd0);
        chk("midreset quotient", div_result, 32'd0);
        chk("midreset remainder", mod_result, 32'd0);
        run_op("after reset", 1, 32'hFFFF_FF9C, 32'd7, 0, 1, 32'hFFFF_FFF2, 32'hFFFF_FFFE);

        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 7);
            a = $urandom;
            b = $urandom;
            case (sel)
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = b >> $urandom_range(8, 30);
                default: ;
            endcase
            if (n % 25 == 7) begin
                div_req = 1; div_signed = 0; div_src1 = a; div_src2 = b;
                tick;
                div_req = 0;
                for (int i = 0; i < int'($urandom_range(0, 34)); i++) tick;
                div_flush = 1;
                tick;
                div_flush = 0;
                tick;
            end
            run_op("rand", 1'($urandom_range(0, 1)), a, b, $urandom_range(0, 3), 0, 32'd0, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Iterative 32-bit integer divider plus its sequencing FSM, for div.w/mod.w/div.wu/mod.wu.
- The execute stage issues a request and stalls until done.
- Results are held stable so the memory stage can select div_result/mod_result one cycle after the instruction leaves execute.
- Handles flush, divide-by-zero and signed overflow deterministically.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- div_req  input  1  execute stage holds a valid div/mod instruction
- div_signed  input  1  1 = signed (div.w/mod.w), 0 = unsigned
- div_src1  input  WIDTH  dividend
- div_src2  input  WIDTH  divisor
- div_ack  input  1  execute-to-memory handoff of the divide instruction (es_to_ms_valid && ms_allowin)
- div_flush  input  1  cancel the in-flight operation
- div_busy  output  1  FSM not IDLE
- div_done  output  1  results valid; execute may set ready_go
- div_result  output  WIDTH  quotient
- mod_result  output  WIDTH  remainder

Behaviour:
- One clock, clk; reset is synchronous and active-high on port reset.
- Reset (including mid-operation): state IDLE, counter 0, div_busy=0, div_done=0, div_result=0, mod_result=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - If div_req && !div_flush: capture div_signed, |src1|, |src2| (abs only when signed), sign of quotient (s1^s2) and sign of remainder (s1); clear partial remainder; counter=0; go to CALC.
  - Requests are sampled only in IDLE; in CALC/DONE div_req is ignored.
- CALC:
  - One restoring shift-subtract step per cycle, MSB first, on a WIDTH+1 bit partial remainder.
  - Counter increments each cycle.
  - When counter==WIDTH-1, write corrected results (negate quotient if sign set, negate remainder if dividend negative) to div_result/mod_result, then go to DONE.
- Latency: request accepted in cycle 0; CALC occupies cycles 1..32; div_done=1 from cycle 33.
- DONE: div_done=1. On div_ack go to IDLE; div_done falls in the next cycle.
- Result hold: div_result/mod_result change only at the CALC-to-DONE transition or on reset. They remain stable in IDLE after the ack, so memory stage reads them in the cycle after handoff.
- div_flush:
  - In CALC or DONE, next state is IDLE and div_done=0 the next cycle.
  - In CALC, results are not written.
  - Flush has priority over div_req (IDLE) and over div_ack (DONE); flush+ack in DONE simply goes to IDLE.
- Divide by zero: runs the full latency, no shortcut. Quotient=all ones, remainder=dividend, for both signed and unsigned. This falls out of restoring division and must not be sign-corrected: sign correction is suppressed when the divisor is 0.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient=0x80000000, remainder=0. This falls out of 33-bit magnitude arithmetic plus negation.
- div_busy = (state != IDLE).
- No combinational path from div_req to div_done.

Decomposition:
- mycpu.vh holds:
  - state encodings DIV_IDLE=2'd0, DIV_CALC=2'd1, DIV_DONE=2'd2;
  - DIV_LATENCY=33;
  - the ms div_op bit meanings (bit0 = select quotient, bit1 = select remainder), shared with execute and memory stages.
- One sub-module, div_step: combinational single restoring iteration. It takes the partial remainder, next dividend bit and divisor, and returns the new partial remainder and quotient bit.
- FSM, counter, sign handling and result registers stay in div_ctrl.

Test Plan:
- Unsigned 100/7, req at cycle 0, ack at cycle 33 -> div_done rises exactly at cycle 33, div_result=14, mod_result=2; both still 14/2 at cycle 34 with div_done=0.
- Signed 0xFFFFFFF9 / 2 (-7/2) -> div_result=0xFFFFFFFD, mod_result=0xFFFFFFFF. Unsigned same operands -> div_result=0x7FFFFFFC, mod_result=1.
- Divide by zero:
  - Unsigned 0x12345678/0 -> div_result=0xFFFFFFFF, mod_result=0x12345678, full 33-cycle latency.
  - Signed 0xFFFFFFF9/0 -> div_result=0xFFFFFFFF, mod_result=0xFFFFFFF9.
- Signed 0x80000000 / 0xFFFFFFFF -> div_result=0x80000000, mod_result=0.
- Flush:
  - Flush at cycle 10 -> div_busy=0 at cycle 11, div_done never asserts, results keep their previous values.
  - Then req 5/5 -> div_done 33 cycles after acceptance, quotient 1, remainder 0.
  - Flush and req together in IDLE -> not accepted.
- Ack held low 5 cycles in DONE -> div_done stays 1, results stable, new div_req ignored.
- Reset asserted at CALC cycle 20 -> next cycle all outputs 0, state IDLE; following request completes normally.
